// File: rtl/tx_frame_arbiter_pkg.sv
// Shared widths, FSM state encoding and source IDs for the UART TX arbiter.
package tx_frame_arbiter_pkg;

    localparam int unsigned ALU_D  = 8;
    localparam int unsigned ALU_W  = 2 * ALU_D;
    localparam int unsigned BCNT_W = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_FREE = 2'd2
    } tx_state_e;

    typedef enum logic {
        SRC_RF  = 1'b0,
        SRC_ALU = 1'b1
    } tx_src_e;

endpackage

// File: rtl/tx_frame_arbiter_if.sv
// Datapath-response and UART TX handshake bundle around the arbiter.
interface tx_frame_arbiter_if
    import tx_frame_arbiter_pkg::*;
;
    logic [ALU_D-1:0] RdData;
    logic             RdData_Valid;
    logic [ALU_W-1:0] ALU_OUT;
    logic             OUT_Valid;
    logic             Busy;
    logic [ALU_D-1:0] TX_P_DATA;
    logic             TX_D_VLD;
    logic             RF_Pending;
    logic             ALU_Pending;
    logic             Overrun;

    modport master (
        output RdData, RdData_Valid, ALU_OUT, OUT_Valid, Busy,
        input  TX_P_DATA, TX_D_VLD, RF_Pending, ALU_Pending, Overrun
    );

    modport slave (
        input  RdData, RdData_Valid, ALU_OUT, OUT_Valid, Busy,
        output TX_P_DATA, TX_D_VLD, RF_Pending, ALU_Pending, Overrun
    );

endinterface

// File: rtl/tx_frame_arbiter.sv
// Round-robin sharing of the UART transmitter between RF read data and
// 16-bit ALU results (sent low byte first), with one holding slot per source.
module tx_frame_arbiter
    import tx_frame_arbiter_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    tx_frame_arbiter_if.slave bus
);

    tx_state_e         state, state_n;
    tx_src_e           last_grant, last_grant_n;
    logic [ALU_D-1:0]  rf_slot, rf_slot_n;
    logic              rf_full, rf_full_n;
    logic [ALU_W-1:0]  alu_slot, alu_slot_n;
    logic              alu_full, alu_full_n;
    logic [ALU_W-1:0]  sh, sh_n;
    logic [BCNT_W-1:0] bcnt, bcnt_n;
    logic              busy_q;
    logic              rf_grant, alu_grant;
    logic              overrun_n;
    logic [ALU_D-1:0]  tx_p_data;
    logic              tx_d_vld;
    logic              overrun;

    // Next-state, grant, shift and slot-capture logic
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        rf_slot_n    = rf_slot;
        rf_full_n    = rf_full;
        alu_slot_n   = alu_slot;
        alu_full_n   = alu_full;
        sh_n         = sh;
        bcnt_n       = bcnt;
        rf_grant     = 1'b0;
        alu_grant    = 1'b0;
        overrun_n    = 1'b0;

        case (state)
            IDLE: begin
                if (rf_full && (!alu_full || last_grant == SRC_ALU)) begin
                    rf_grant = 1'b1;
                end else if (alu_full) begin
                    alu_grant = 1'b1;
                end
                if (rf_grant) begin
                    sh_n         = ALU_W'(rf_slot);
                    bcnt_n       = BCNT_W'(1);
                    rf_full_n    = 1'b0;
                    last_grant_n = SRC_RF;
                    state_n      = SEND;
                end else if (alu_grant) begin
                    sh_n         = alu_slot;
                    bcnt_n       = BCNT_W'(2);
                    alu_full_n   = 1'b0;
                    last_grant_n = SRC_ALU;
                    state_n      = SEND;
                end
            end
            SEND: begin
                // Only a fresh rising edge of Busy means the byte was taken
                if (bus.Busy && !busy_q) begin
                    bcnt_n  = bcnt - BCNT_W'(1);
                    state_n = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (!bus.Busy) begin
                    if (bcnt != '0) begin
                        sh_n    = sh >> ALU_D;
                        state_n = SEND;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A slot being granted this cycle is free to take a new response
        if (bus.RdData_Valid) begin
            if (!rf_full || rf_grant) begin
                rf_slot_n = bus.RdData;
                rf_full_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end
        if (bus.OUT_Valid) begin
            if (!alu_full || alu_grant) begin
                alu_slot_n = bus.ALU_OUT;
                alu_full_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= SRC_ALU;
            rf_slot    <= '0;
            rf_full    <= 1'b0;
            alu_slot   <= '0;
            alu_full   <= 1'b0;
            sh         <= '0;
            bcnt       <= '0;
            busy_q     <= 1'b0;
            tx_p_data  <= '0;
            tx_d_vld   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            rf_slot    <= rf_slot_n;
            rf_full    <= rf_full_n;
            alu_slot   <= alu_slot_n;
            alu_full   <= alu_full_n;
            sh         <= sh_n;
            bcnt       <= bcnt_n;
            busy_q     <= bus.Busy;
            tx_p_data  <= sh_n[ALU_D-1:0];
            tx_d_vld   <= (state_n == SEND);
            overrun    <= overrun_n;
        end
    end

    assign bus.TX_P_DATA   = tx_p_data;
    assign bus.TX_D_VLD    = tx_d_vld;
    assign bus.RF_Pending  = rf_full;
    assign bus.ALU_Pending = alu_full;
    assign bus.Overrun     = overrun;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter with a UART Busy model that records sent bytes.
module tb_tx_frame_arbiter;
    import tx_frame_arbiter_pkg::*;

    typedef struct {
        logic        rd_vld;
        logic [7:0]  rd;
        logic        out_vld;
        logic [15:0] alu;
        int          n;
        logic [31:0] exp;
        logic        rfp;
        logic        alup;
    } vec_t;

    localparam int NV = 7;

    logic CLK = 1'b0;
    logic RST;
    logic busy_force;
    logic busy_m;

    int vec_cnt;
    int err_cnt;
    int hold, dly, ovr_cnt, vld_in_busy;
    logic [7:0] sent[$];
    vec_t vecs[NV];

    tx_frame_arbiter_if bus();

    tx_frame_arbiter dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    assign bus.Busy = busy_force | busy_m;

    // UART model: Busy rises 2 cycles after TX_D_VLD, stays high 10 cycles
    initial begin : busy_model
        busy_m = 1'b0; hold = 0; dly = 0; ovr_cnt = 0; vld_in_busy = 0;
        forever begin
            @(negedge CLK);
            if (bus.Overrun) ovr_cnt++;
            if (RST) begin
                busy_m = 1'b0; dly = 0; hold = 0;
            end else if (busy_m) begin
                if (bus.TX_D_VLD) vld_in_busy++;
                if (hold == 0) busy_m = 1'b0;
                else hold--;
            end else if (busy_force || !bus.TX_D_VLD) begin
                dly = 0;
            end else if (dly == 1) begin
                sent.push_back(bus.TX_P_DATA);
                busy_m = 1'b1; hold = 9; dly = 0;
            end else begin
                dly++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse(input logic rv, input logic [7:0] rd, input logic ov, input logic [15:0] alu);
        @(negedge CLK);
        bus.RdData = rd; bus.RdData_Valid = rv;
        bus.ALU_OUT = alu; bus.OUT_Valid = ov;
        @(negedge CLK);
        bus.RdData_Valid = 1'b0; bus.OUT_Valid = 1'b0;
    endtask

    task automatic wait_idle(input int base, input int n);
        bit done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge CLK);
            if (sent.size() >= base + n && !bus.Busy && !bus.TX_D_VLD &&
                !bus.RF_Pending && !bus.ALU_Pending)
                done = 1'b1;
        end
        check("idle_timeout", 32'(done), 32'd1);
        repeat (6) @(negedge CLK);
    endtask

    task automatic check_bytes(input string name, input int base, input int n, input logic [31:0] exp);
        check({name, "_count"}, 32'(sent.size() - base), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (base + k < sent.size())
                check({name, "_byte"}, 32'(sent[base + k]), 32'(exp[8*k +: 8]));
        end
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        int base, vib0, ovr0;
        base = sent.size(); vib0 = vld_in_busy; ovr0 = ovr_cnt;
        pulse(v.rd_vld, v.rd, v.out_vld, v.alu);
        check({name, "_rf_pend"}, 32'(bus.RF_Pending), 32'(v.rd_vld));
        check({name, "_alu_pend"}, 32'(bus.ALU_Pending), 32'(v.out_vld));
        @(negedge CLK);
        check({name, "_vld_latency"}, 32'(bus.TX_D_VLD), 32'd1);
        check({name, "_first_byte"}, 32'(bus.TX_P_DATA), 32'(v.exp[7:0]));
        check({name, "_grant_rf_pend"}, 32'(bus.RF_Pending), 32'(v.rfp));
        check({name, "_grant_alu_pend"}, 32'(bus.ALU_Pending), 32'(v.alup));
        wait_idle(base, v.n);
        check_bytes(name, base, v.n, v.exp);
        check({name, "_vld_in_busy"}, 32'(vld_in_busy - vib0), 32'd0);
        check({name, "_overrun"}, 32'(ovr_cnt - ovr0), 32'd0);
    endtask

    initial begin : main
        int base, ovr0, rbase;
        bit seen;
        vec_cnt = 0; err_cnt = 0;
        busy_force = 1'b0; RST = 1'b1;
        bus.RdData = '0; bus.RdData_Valid = 1'b0;
        bus.ALU_OUT = '0; bus.OUT_Valid = 1'b0;

        vecs[0] = '{rd_vld:1'b1, rd:8'hAA, out_vld:1'b1, alu:16'hBEEF, n:3, exp:32'h00BEEFAA, rfp:1'b0, alup:1'b1};
        vecs[1] = '{rd_vld:1'b1, rd:8'h5A, out_vld:1'b0, alu:16'h0000, n:1, exp:32'h0000005A, rfp:1'b0, alup:1'b0};
        vecs[2] = '{rd_vld:1'b0, rd:8'h00, out_vld:1'b1, alu:16'h1234, n:2, exp:32'h00001234, rfp:1'b0, alup:1'b0};
        vecs[3] = '{rd_vld:1'b1, rd:8'h11, out_vld:1'b0, alu:16'h0000, n:1, exp:32'h00000011, rfp:1'b0, alup:1'b0};
        vecs[4] = '{rd_vld:1'b1, rd:8'hAA, out_vld:1'b1, alu:16'hBEEF, n:3, exp:32'h00AABEEF, rfp:1'b1, alup:1'b0};
        vecs[5] = '{rd_vld:1'b0, rd:8'h00, out_vld:1'b1, alu:16'hFFFF, n:2, exp:32'h0000FFFF, rfp:1'b0, alup:1'b0};
        vecs[6] = '{rd_vld:1'b1, rd:8'h00, out_vld:1'b0, alu:16'h0000, n:1, exp:32'h00000000, rfp:1'b0, alup:1'b0};

        #1;
        check("rst_tx_p_data", 32'(bus.TX_P_DATA), 32'd0);
        check("rst_tx_d_vld", 32'(bus.TX_D_VLD), 32'd0);
        check("rst_rf_pend", 32'(bus.RF_Pending), 32'd0);
        check("rst_alu_pend", 32'(bus.ALU_Pending), 32'd0);
        check("rst_overrun", 32'(bus.Overrun), 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < NV; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

        // Overrun: RF slot held full while the FSM is stuck behind a high Busy
        base = sent.size(); ovr0 = ovr_cnt;
        busy_force = 1'b1;
        pulse(1'b0, 8'h00, 1'b1, 16'h2211);
        @(negedge CLK);
        check("ovr_stuck_vld", 32'(bus.TX_D_VLD), 32'd1);
        pulse(1'b1, 8'h33, 1'b0, 16'h0000);
        check("ovr_rf_pend", 32'(bus.RF_Pending), 32'd1);
        pulse(1'b1, 8'h77, 1'b0, 16'h0000);
        check("ovr_pulse", 32'(bus.Overrun), 32'd1);
        @(negedge CLK);
        check("ovr_pulse_end", 32'(bus.Overrun), 32'd0);
        repeat (4) @(negedge CLK);
        check("ovr_still_byte0", 32'(bus.TX_P_DATA), 32'h11);
        check("ovr_still_vld", 32'(bus.TX_D_VLD), 32'd1);
        busy_force = 1'b0;
        wait_idle(base, 3);
        check_bytes("ovr_frames", base, 3, 32'h00332211);
        check("ovr_count", 32'(ovr_cnt - ovr0), 32'd1);

        // Second ALU result arriving in the grant cycle of the first
        base = sent.size(); ovr0 = ovr_cnt;
        @(negedge CLK);
        bus.ALU_OUT = 16'h0102; bus.OUT_Valid = 1'b1;
        @(negedge CLK);
        bus.ALU_OUT = 16'h0304;
        @(negedge CLK);
        bus.OUT_Valid = 1'b0;
        check("b2b_alu_pend", 32'(bus.ALU_Pending), 32'd1);
        check("b2b_first_byte", 32'(bus.TX_P_DATA), 32'h02);
        wait_idle(base, 4);
        check_bytes("b2b", base, 4, 32'h03040102);
        check("b2b_overrun", 32'(ovr_cnt - ovr0), 32'd0);

        // Reset while byte1 of an ALU frame is being offered
        base = sent.size();
        pulse(1'b0, 8'h00, 1'b1, 16'hCAFE);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge CLK);
            if (sent.size() > base) seen = 1'b1;
        end
        check("rstmid_byte0_seen", 32'(seen), 32'd1);
        pulse(1'b1, 8'h99, 1'b0, 16'h0000);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge CLK);
            if (bus.TX_D_VLD) seen = 1'b1;
        end
        check("rstmid_byte1_vld", 32'(seen), 32'd1);
        check("rstmid_byte0", 32'(sent[base]), 32'hFE);
        check("rstmid_byte1", 32'(bus.TX_P_DATA), 32'hCA);
        check("rstmid_rf_pend", 32'(bus.RF_Pending), 32'd1);
        #2 RST = 1'b1;
        #1;
        rbase = sent.size();
        check("rstmid_tx_p_data", 32'(bus.TX_P_DATA), 32'd0);
        check("rstmid_tx_d_vld", 32'(bus.TX_D_VLD), 32'd0);
        check("rstmid_rf_pend_clr", 32'(bus.RF_Pending), 32'd0);
        check("rstmid_alu_pend", 32'(bus.ALU_Pending), 32'd0);
        check("rstmid_overrun", 32'(bus.Overrun), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        check("rstmid_no_byte1", 32'(sent.size() - rbase), 32'd0);
        check("rstmid_idle_vld", 32'(bus.TX_D_VLD), 32'd0);

        // Round-robin restarts with RF winning the first tie after reset
        apply_vec("post_rst", '{rd_vld:1'b1, rd:8'h3C, out_vld:1'b1, alu:16'h5566,
                                n:3, exp:32'h0055663C, rfp:1'b0, alup:1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
